// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One multiplier bit per cycle over magnitudes, sign fixed up in a final cycle.
module multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     multiplicand_i,
  input  logic [WIDTH-1:0]     multiplier_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic [WIDTH-1:0]     result_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH:0]       acc_q, acc_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [1:0]             op_q, op_d;
  logic                   neg_q, neg_d;
  logic [2*WIDTH-1:0]     product_q, product_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   done_q, done_d;

  logic                   a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         add_sum;
  logic [2*WIDTH-1:0]     prod_fix;

  // Magnitude of the most negative value wraps to itself, which is the
  // correct unsigned magnitude 2^(WIDTH-1).
  assign a_neg = ((op_i == OP_MULH) || (op_i == OP_MULHSU)) && multiplicand_i[WIDTH-1];
  assign b_neg = (op_i == OP_MULH) && multiplier_i[WIDTH-1];
  assign a_mag = a_neg ? -multiplicand_i : multiplicand_i;
  assign b_mag = b_neg ? -multiplier_i : multiplier_i;

  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
  assign prod_fix = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];

  // NOTE: every *_d gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    op_d      = op_q;
    neg_d     = neg_q;
    product_d = product_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CALC;
          cnt_d   = CNT_W'(WIDTH - 1);
          acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
          mcand_d = a_mag;
          op_d    = op_i;
          neg_d   = a_neg ^ b_neg;
        end
      end
      CALC: begin
        // Multiplier bits drain out of the low half while the product
        // grows in from the top, carry kept in the extra MSB.
        acc_d = acc_q[0] ? ({add_sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        product_d = prod_fix;
        result_d  = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign product_o = product_q;
  assign result_o  = result_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

endmodule
